// File: rtl/tanh_hgate_if.sv
// Handshake bundle between tanh_hgate, its og source, the tanh unit and the h consumer.
// The master modport is the tanh_hgate side; slave is the surrounding environment.
interface tanh_hgate_if #(
   parameter int W = 32
);
   logic [W-1:0] og;
   logic         og_valid;
   logic         og_take;
   logic [W-1:0] tanh;
   logic         en;
   logic         wa;
   logic         comp;
   logic [W-1:0] h;
   logic         h_valid;
   logic         h_ack;

   modport master (
      input  og, og_valid, tanh, en, h_ack,
      output og_take, wa, comp, h, h_valid
   );

   modport slave (
      output og, og_valid, tanh, en, h_ack,
      input  og_take, wa, comp, h, h_valid
   );
endinterface

// File: rtl/tanh_hgate.sv
// Consumer end of the tanh unit handshake: takes an output-gate value, releases the
// tanh unit, captures its result, and produces the saturated Q5.26 product h = og * tanh.
module tanh_hgate #(
   parameter int W    = 32,
   parameter int FRAC = 26
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          locked,
   tanh_hgate_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_T,
      ACK,
      MUL,
      SAT,
      OUT
   } state_t;

   // Largest and smallest Q5.26 values, widened to the product width for clamping
   localparam logic signed [2*W-1:0] HMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W-1:0] HMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

   state_t                 state_q, state_d;
   logic [W-1:0]           og_q, og_d;
   logic [W-1:0]           tanh_q, tanh_d;
   logic signed [2*W-1:0]  prod_q, prod_d;
   logic [W-1:0]           h_q, h_d;
   logic                   hValid_q, hValid_d;
   logic                   wa_q, wa_d;
   logic                   comp_q, comp_d;
   logic                   ogTake_q, ogTake_d;

   logic signed [2*W-1:0]  ogWide;
   logic signed [2*W-1:0]  tanhWide;
   logic signed [2*W-1:0]  prodFull;
   logic signed [2*W-1:0]  prodShifted;

   // Sign-extend both operands to full product width so the multiply is exact Q10.52
   always_comb begin
      ogWide      = {{W{og_q[W-1]}}, og_q};
      tanhWide    = {{W{tanh_q[W-1]}}, tanh_q};
      prodFull    = ogWide * tanhWide;
      prodShifted = prod_q >>> FRAC;
   end

   // Next-state and output-register logic; clamping the shifted product to the W-bit
   // range is the same test as requiring the top product bits to be all equal
   always_comb begin
      state_d  = state_q;
      og_d     = og_q;
      tanh_d   = tanh_q;
      prod_d   = prod_q;
      h_d      = h_q;
      hValid_d = hValid_q;
      wa_d     = wa_q;
      comp_d   = comp_q;
      ogTake_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.og_valid) begin
               og_d     = bus.og;
               ogTake_d = 1'b1;
               wa_d     = 1'b0;
               state_d  = WAIT_T;
            end
         end
         WAIT_T: begin
            if (bus.en) begin
               tanh_d  = bus.tanh;
               comp_d  = 1'b1;
               wa_d    = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            if (!bus.en) begin
               comp_d  = 1'b0;
               state_d = MUL;
            end
         end
         MUL: begin
            prod_d  = prodFull;
            state_d = SAT;
         end
         SAT: begin
            if (prodShifted > HMAX) begin
               h_d = {1'b0, {(W-1){1'b1}}};
            end else if (prodShifted < HMIN) begin
               h_d = {1'b1, {(W-1){1'b0}}};
            end else begin
               h_d = prodShifted[W-1:0];
            end
            hValid_d = 1'b1;
            state_d  = OUT;
         end
         OUT: begin
            if (bus.h_ack) begin
               hValid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; locked acts as a synchronous clear with the same effect as reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         og_q     <= '0;
         tanh_q   <= '0;
         prod_q   <= '0;
         h_q      <= '0;
         hValid_q <= 1'b0;
         wa_q     <= 1'b1;
         comp_q   <= 1'b0;
         ogTake_q <= 1'b0;
      end else if (locked) begin
         state_q  <= IDLE;
         og_q     <= '0;
         tanh_q   <= '0;
         prod_q   <= '0;
         h_q      <= '0;
         hValid_q <= 1'b0;
         wa_q     <= 1'b1;
         comp_q   <= 1'b0;
         ogTake_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         og_q     <= og_d;
         tanh_q   <= tanh_d;
         prod_q   <= prod_d;
         h_q      <= h_d;
         hValid_q <= hValid_d;
         wa_q     <= wa_d;
         comp_q   <= comp_d;
         ogTake_q <= ogTake_d;
      end
   end

   assign bus.og_take = ogTake_q;
   assign bus.wa      = wa_q;
   assign bus.comp    = comp_q;
   assign bus.h       = h_q;
   assign bus.h_valid = hValid_q;

endmodule

// File: tb/tb_tanh_hgate.sv
// Directed-vector bench for tanh_hgate: the bench plays the og source, a conforming
// tanh unit and the h consumer, with hand-computed expected products.
module tb_tanh_hgate;

   logic clk    = 1'b0;
   logic rst    = 1'b0;
   logic locked = 1'b0;

   int checkCount = 0;
   int passCount  = 0;

   tanh_hgate_if #(.W(32)) bus ();

   tanh_hgate #(.W(32), .FRAC(26)) dut (
      .clk    (clk),
      .rst    (rst),
      .locked (locked),
      .bus    (bus.master)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Safety net in case the design stalls somewhere unexpected
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " wa"},      32'(bus.wa),      32'd1);
      checkOutput({tag, " comp"},    32'(bus.comp),    32'd0);
      checkOutput({tag, " og_take"}, 32'(bus.og_take), 32'd0);
      checkOutput({tag, " h"},       bus.h,            32'h0);
      checkOutput({tag, " h_valid"}, 32'(bus.h_valid), 32'd0);
   endtask

   task automatic waitHValid(output int edges);
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (bus.h_valid !== 1'b1 && edges < 8);
   endtask

   // Present og in IDLE and confirm the one-cycle take pulse and tanh-unit release
   task automatic startTxn(input logic [31:0] ogVal, input string tag);
      @(negedge clk);
      bus.og       = ogVal;
      bus.og_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput({tag, " og_take rise"}, 32'(bus.og_take), 32'd1);
      checkOutput({tag, " wa low"},       32'(bus.wa),      32'd0);
      @(negedge clk);
      bus.og_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, " og_take pulse"}, 32'(bus.og_take), 32'd0);
      checkOutput({tag, " wa still low"},  32'(bus.wa),      32'd0);
   endtask

   // Behave as a conforming tanh unit: raise en, drop it one edge after seeing comp
   task automatic feedTanh(input logic [31:0] tanhVal, input string tag);
      @(negedge clk);
      bus.en   = 1'b1;
      bus.tanh = tanhVal;
      @(posedge clk);
      #1;
      checkOutput({tag, " comp rise"}, 32'(bus.comp), 32'd1);
      checkOutput({tag, " wa park"},   32'(bus.wa),   32'd1);
      @(posedge clk);
      #1;
      checkOutput({tag, " comp cycle2"}, 32'(bus.comp), 32'd1);
      bus.en = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, " comp fall"}, 32'(bus.comp), 32'd0);
   endtask

   // Collect h, optionally with h_ack already high when it appears
   task automatic collectH(input logic [31:0] expH, input bit ackEarly, input string tag);
      int   edges;
      logic [31:0] held;
      if (ackEarly) begin
         @(negedge clk);
         bus.h_ack = 1'b1;
      end
      waitHValid(edges);
      checkOutput({tag, " h latency"}, 32'(edges), 32'd2);
      checkOutput({tag, " h"},         bus.h,      expH);
      checkOutput({tag, " wa in OUT"}, 32'(bus.wa), 32'd1);
      held = bus.h;
      if (ackEarly) begin
         @(posedge clk);
         #1;
         checkOutput({tag, " h_valid 1cyc"}, 32'(bus.h_valid), 32'd0);
         @(negedge clk);
         bus.h_ack = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         checkOutput({tag, " h_valid held"}, 32'(bus.h_valid), 32'd1);
         checkOutput({tag, " h held"},       bus.h,            held);
         @(negedge clk);
         bus.h_ack = 1'b1;
         @(posedge clk);
         #1;
         checkOutput({tag, " h_valid drop"}, 32'(bus.h_valid), 32'd0);
         @(negedge clk);
         bus.h_ack = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] ogVal, input logic [31:0] tanhVal,
                                input logic [31:0] expH, input bit ackEarly, input string tag);
      startTxn(ogVal, tag);
      feedTanh(tanhVal, tag);
      collectH(expH, ackEarly, tag);
   endtask

   // Abort a transaction in WAIT_T or ACK with either rst or locked
   task automatic abortTest(input bit useRst, input bit inAck, input string tag);
      startTxn(32'h0400_0000, tag);
      if (inAck) begin
         @(negedge clk);
         bus.en   = 1'b1;
         bus.tanh = 32'h0200_0000;
         @(posedge clk);
         #1;
         checkOutput({tag, " in ACK"}, 32'(bus.comp), 32'd1);
      end
      @(negedge clk);
      if (useRst) begin
         rst = 1'b0;
         #1;
         checkIdle({tag, " async"});
      end else begin
         locked = 1'b1;
         @(posedge clk);
         #1;
         checkIdle({tag, " locked"});
      end
      @(negedge clk);
      bus.en = 1'b0;
      rst    = 1'b1;
      locked = 1'b0;
      @(posedge clk);
      #1;
      checkIdle({tag, " after"});
   endtask

   logic [31:0] vecOg   [8] = '{32'h0200_0000, 32'h0400_0000, 32'hFFFF_FFFF, 32'h0000_0001,
                                32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFC00_0000};
   logic [31:0] vecTanh [8] = '{32'h01D9_353D, 32'hFC00_0000, 32'h0000_0001, 32'h0000_0001,
                                32'h0800_0000, 32'h0800_0000, 32'h0400_0000, 32'hFE00_0000};
   logic [31:0] vecH    [8] = '{32'h00EC_9A9E, 32'hFC00_0000, 32'hFFFF_FFFF, 32'h0000_0000,
                                32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0200_0000};
   bit          vecAck  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      int          edges;
      logic [31:0] heldH;

      bus.og       = '0;
      bus.og_valid = 1'b0;
      bus.tanh     = '0;
      bus.en       = 1'b0;
      bus.h_ack    = 1'b0;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.og       = $urandom;
         bus.og_valid = 1'($urandom_range(0, 1));
         bus.tanh     = $urandom;
         bus.en       = 1'($urandom_range(0, 1));
         bus.h_ack    = 1'($urandom_range(0, 1));
         #1;
         checkIdle($sformatf("reset%0d", i));
      end
      @(negedge clk);
      bus.og_valid = 1'b0;
      bus.en       = 1'b0;
      bus.h_ack    = 1'b0;
      rst          = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkIdle("post-reset");

      // Directed product vectors
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecOg[i], vecTanh[i], vecH[i], vecAck[i], $sformatf("vec%0d", i));
      end

      // Backpressure with a waiting og source
      startTxn(32'h0400_0000, "bp");
      feedTanh(32'h0200_0000, "bp");
      waitHValid(edges);
      checkOutput("bp h", bus.h, 32'h0200_0000);
      heldH = bus.h;
      @(negedge clk);
      bus.og       = 32'h0080_0000;
      bus.og_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("bp h stable%0d", i),  bus.h,               heldH);
         checkOutput($sformatf("bp h_valid%0d", i),   32'(bus.h_valid),    32'd1);
         checkOutput($sformatf("bp wa%0d", i),        32'(bus.wa),         32'd1);
         checkOutput($sformatf("bp no take%0d", i),   32'(bus.og_take),    32'd0);
      end
      @(negedge clk);
      bus.h_ack = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp h_valid drop", 32'(bus.h_valid), 32'd0);
      checkOutput("bp take not yet", 32'(bus.og_take), 32'd0);
      @(negedge clk);
      bus.h_ack = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("bp next take", 32'(bus.og_take), 32'd1);
      @(negedge clk);
      bus.og_valid = 1'b0;
      feedTanh(32'hFC00_0000, "bp2");
      collectH(32'hFF80_0000, 1'b0, "bp2");

      // Aborts in WAIT_T and ACK, each followed by a clean transaction
      abortTest(1'b0, 1'b0, "lock-wait");
      abortTest(1'b1, 1'b0, "rst-wait");
      abortTest(1'b0, 1'b1, "lock-ack");
      abortTest(1'b1, 1'b1, "rst-ack");
      applyStimulus(32'h0400_0000, 32'hFC00_0000, 32'hFC00_0000, 1'b0, "post-abort");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/tanh_hgate.md
# tanh_hgate

Consumer end of the tanh unit's `wa`/`en`/`comp` handshake. It holds the tanh unit idle through `wa` until an output-gate value arrives, then releases it. It captures the tanh result on `en` and acknowledges with `comp`. It then computes the hidden-state term h = og × tanh in Q5.26 fixed point, with saturation, and presents h downstream under a valid/ack handshake.

## Interface
- `W`, 32, data width; sign + 5 integer + 26 fraction bits (Q5.26).
- `FRAC`, 26, fraction bits; product scaling shift.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `locked`  in  1  high = synchronous clear to reset values, same effect as `rst` while high.
- `og`  in  W  signed Q5.26 output-gate value.
- `og_valid`  in  1  `og` valid; level, held by source until `og_take`.
- `og_take`  out  1  one-cycle pulse: `og` captured.
- `tanh`  in  W  signed Q5.26 result from the tanh unit.
- `en`  in  1  tanh unit result valid; stays high until `comp` is seen.
- `wa`  out  1  high = hold the tanh unit in its idle state.
- `comp`  out  1  acknowledge to the tanh unit; it drops `en` and returns to idle.
- `h`  out  W  signed Q5.26 result og × tanh.
- `h_valid`  out  1  `h` valid.
- `h_ack`  in  1  downstream accepts `h`.

## Operation
- Reset/locked values: state IDLE, `wa`=1, `comp`=0, `og_take`=0, `h`=0, `h_valid`=0. Internal og/tanh/product registers are cleared to 0.
- **IDLE:** `wa`=1. When `og_valid`=1:
  - latch `og`;
  - pulse `og_take`;
  - set `wa`<=0;
  - go to WAIT_T.
- **WAIT_T:** `wa`=0. When `en`=1:
  - latch `tanh`;
  - set `comp`<=1 and `wa`<=1 in the same edge;
  - go to ACK.
  - Setting `wa`=1 together with `comp` guarantees the tanh unit parks at idle after it drops `en`.
- **ACK:** `comp`=1 is held until `en`=0 is sampled. Then `comp`<=0 and go to MUL.
- **MUL:** compute the 2W-bit signed product og × tanh (Q10.52) into a register. Go to SAT.
- **SAT:**
  - Compute r = product >>> FRAC (arithmetic shift, truncation toward −∞).
  - If product bits [2W−1 : W+FRAC−1] are not all equal, saturate: `h`=0x7FFFFFFF when positive, 0x80000000 when negative.
  - Otherwise `h` = r[W−1:0].
  - Set `h_valid`<=1 and go to OUT.
- **OUT:** `h` and `h_valid` are held stable until `h_ack`=1 is sampled. Then `h_valid`<=0 and go to IDLE.
- `og_valid` is ignored outside IDLE. `en` is ignored outside WAIT_T and ACK.
- A new `og` can be taken at the earliest one cycle after `h_valid` falls, since `og_valid` is sampled again only in IDLE.

## Timing
- `og_take` and `wa` falling occur on the edge that samples `og_valid`=1 in IDLE.
- `comp` rises one edge after `en` is first presented. `tanh` is captured on that same edge.
- With a conforming tanh unit (drops `en` one edge after seeing `comp`), `comp` is high for exactly 2 cycles.
- `h_valid` rises 2 edges after leaving ACK (MUL, then SAT).
- `h_ack` already high when `h_valid` rises: `h_valid` is high for 1 cycle.
- Async `rst` low or `locked` high mid-operation (any state): immediate return to reset values. `wa`=1 re-parks the tanh unit. Any partial result is discarded and `og_take` is not re-issued.
- `en` dropping in WAIT_T without `comp` cannot occur; if it does, WAIT_T persists.

## Test plan
- **Reset:** `rst`=0 with random inputs → `wa`=1, `comp`=0, `og_take`=0, `h`=0, `h_valid`=0. After release, with `og_valid`=0, the outputs stay at those values.
- **Nominal, with the real tanh unit:** `og`=0x02000000 (0.5); tanh unit fed 0.5 produces ≈0x01D9… → `h` = (og × tanh) >>> 26, bit-exact against the model. Also check: `og_take` is a 1-cycle pulse, `wa` is low only between `og_take` and `comp`, and `comp` lasts 2 cycles.
- **Sign, using a stub producer:** `og`=0x04000000 (1.0), `tanh`=0xFC000000 (−1.0) → `h`=0xFC000000. Rounding: `og`=0xFFFFFFFF, `tanh`=0x00000001 → `h`=0xFFFFFFFF; `og`=1, `tanh`=1 → `h`=0.
- **Saturation:**
  - `og`=0x7FFFFFFF, `tanh`=0x08000000 (2.0) → `h`=0x7FFFFFFF.
  - `og`=0x80000000, `tanh`=0x08000000 → `h`=0x80000000.
  - `og`=0x7FFFFFFF, `tanh`=0x04000000 → `h`=0x7FFFFFFF (exact, no saturation).
- **Backpressure:** hold `h_ack`=0 for 10 cycles with `og_valid`=1 → `h`/`h_valid` stable, `wa`=1, no `og_take`. On `h_ack`=1, `h_valid` drops next edge; the next `og_take` follows one cycle later.
- **Abort:** pulse `locked` (and separately `rst`) in WAIT_T, then in ACK → all outputs return to reset values on that edge. A subsequent transaction completes normally with the correct `h`.
